parking_spot_allocator: RTL
===========================

Name: parking_spot_allocator

Overview:
Sequential producer of the 8-bit occupancy vector consumed by parking_capacity_counter (bit i = 1 means spot i occupied). Handles the entry gate through a req/ack/nack handshake, assigns the lowest-numbered free spot and times the gate-open pulse. Handles exit events by clearing the leaving car's spot. Sits between the gate sensors/controller and the capacity counter/display path.

Parameters:
NUM_SPOTS, 8, number of spots; occupancy vector width.
IDX_W, 3, spot index width; ceil(log2(NUM_SPOTS)).
GATE_CYCLES, 4, clock cycles gate_open stays high per granted entry (>=1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
arrive_req  input  1  entry request level; held high by requester until ack or nack seen.
arrive_ack  output  1  one-cycle pulse: spot granted.
arrive_nack  output  1  one-cycle pulse: lot full, entry refused.
assigned_spot  output  IDX_W  spot index granted; valid with arrive_ack, held until next grant.
gate_open  output  1  entry gate open command.
leave_valid  input  1  one-cycle exit event.
leave_spot  input  IDX_W  spot vacated, qualified by leave_valid.
exit_err  output  1  one-cycle pulse: exit on free or out-of-range spot.
occupancy  output  NUM_SPOTS  occupancy vector (new_capacity for the counter).
full  output  1  all spots occupied (combinational AND of occupancy).
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n=0): occupancy=0, assigned_spot=0, arrive_ack=0, arrive_nack=0, gate_open=0, exit_err=0, state=IDLE, gate counter=0. Reset mid-handshake aborts it; no ack issued. Requester re-raises req.
- All outputs are registered except full and busy.
- FSM states: IDLE, ALLOC, GATE, WAIT_DROP.
- IDLE: arrive_req=1 sampled at edge N -> ALLOC.
- ALLOC (one cycle): evaluates the priority encoder (lowest index with bit=0) on occupancy as it stands in that cycle.
  - Free spot found: at edge N+1 set that bit, load assigned_spot, arrive_ack=1 for one cycle, gate_open=1, state=GATE.
  - No free spot (full): at edge N+1 arrive_nack=1 for one cycle, gate_open stays 0, state=WAIT_DROP.
  - Latency is request sampled -> ack/nack visible = 1 cycle after the ALLOC edge (2 edges total).
- GATE: gate_open held high for exactly GATE_CYCLES cycles from edge N+1, then cleared; state=WAIT_DROP.
- WAIT_DROP: waits for arrive_req=0, then goes to IDLE. A request held high is never served twice.
- Exit path runs in parallel with the FSM every cycle:
  - leave_valid=1 with occupancy[leave_spot]=1: clear the bit at that edge.
  - leave_spot on a free spot, or leave_spot >= NUM_SPOTS: occupancy unchanged, exit_err pulses one cycle.
- Same-edge set and clear: an ALLOC set always targets a free bit and a valid exit always clears an occupied bit, so they never hit the same bit. Both updates apply at the same edge.
- Exit in the ALLOC cycle: the encoder sees the pre-exit vector. If the lot was full, nack is still issued even though a spot frees at that edge. This is the intended behaviour.
- Full boundary: after the 8th grant, occupancy=8'hFF and full=1. Any exit drops full the next cycle.
- Empty boundary: an exit when occupancy=0 produces exit_err.

Decomposition:
- Shared package/header: NUM_SPOTS, IDX_W, FSM state encodings (IDLE=0, ALLOC=1, GATE=2, WAIT_DROP=3).
- One sub-module: spot_priority_encoder, combinational.
  - Inputs: occupancy.
  - Outputs: free_idx[IDX_W-1:0] and any_free.
  - Lowest free index wins.

Test Plan:
1. Reset, then arrive_req=1 -> ack 2 edges later, assigned_spot=0, occupancy=8'h01, gate_open high exactly 4 cycles; drop req -> busy=0.
2. Eight sequential entries -> assigned_spot 0..7, occupancy=8'hFF, full=1; 9th req -> arrive_nack pulse, gate_open stays 0, occupancy unchanged.
3. From 8'hFF, leave_spot=3 -> occupancy=8'hF7; next entry -> assigned_spot=3, occupancy=8'hFF (lowest-hole refill).
4. From 8'h01, leave_spot=5 -> exit_err one-cycle pulse, occupancy stays 8'h01.
5. occupancy=8'h0F, exit spot 1 in the same cycle as ALLOC -> spot 4 granted and spot 1 cleared at the same edge, occupancy=8'h1D.
6. rst_n low during GATE with occupancy=8'h07 -> gate_open=0, occupancy=0, no ack; req held after release -> new grant of spot 0.

Source files
------------

// File: rtl/parking_spot_allocator_pkg.sv
// parking_spot_allocator_pkg: shared sizes and FSM encoding for the spot allocator
package parking_spot_allocator_pkg;
  localparam int NUM_SPOTS   = 8;
  localparam int IDX_W       = 3;
  localparam int GATE_CYCLES = 4;
  localparam int CNT_W       = $clog2(GATE_CYCLES + 1);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALLOC     = 2'd1,
    GATE      = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;
endpackage

// File: rtl/parking_spot_allocator_spot_priority_encoder.sv
// spot_priority_encoder: lowest-numbered free spot in the occupancy vector
module spot_priority_encoder
  import parking_spot_allocator_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] occupancy,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 any_free
);
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--)
      if (!occupancy[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
  end
endmodule

// File: rtl/parking_spot_allocator.sv
// parking_spot_allocator: entry handshake, lowest-free spot grant, gate timing and exit clearing
module parking_spot_allocator
  import parking_spot_allocator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arrive_req,
  output logic                 arrive_ack,
  output logic                 arrive_nack,
  output logic [IDX_W-1:0]     assigned_spot,
  output logic                 gate_open,
  input  logic                 leave_valid,
  input  logic [IDX_W-1:0]     leave_spot,
  output logic                 exit_err,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic                 full,
  output logic                 busy
);
  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     free_idx, spot_d;
  logic                 any_free, ack_d, nack_d, gate_d, err_d, leave_ok;
  logic [NUM_SPOTS-1:0] set_mask, clr_mask;

  spot_priority_encoder u_enc (
    .occupancy(occupancy),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign full = &occupancy;
  assign busy = state != IDLE;

  // exit path is independent of the FSM; it never clears the bit ALLOC is setting
  always_comb begin
    leave_ok = leave_valid && (int'(leave_spot) < NUM_SPOTS) && occupancy[leave_spot];
    clr_mask = leave_ok ? NUM_SPOTS'(1) << leave_spot : '0;
    err_d    = leave_valid && !leave_ok;
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    spot_d   = assigned_spot;
    ack_d    = 1'b0;
    nack_d   = 1'b0;
    gate_d   = gate_open;
    set_mask = '0;
    unique case (state)
      IDLE: state_d = arrive_req ? ALLOC : IDLE;
      ALLOC:
        if (any_free) begin
          set_mask[free_idx] = 1'b1;
          spot_d  = free_idx;
          ack_d   = 1'b1;
          gate_d  = 1'b1;
          cnt_d   = CNT_W'(GATE_CYCLES - 1);
          state_d = GATE;
        end else begin
          nack_d  = 1'b1;
          state_d = WAIT_DROP;
        end
      GATE:
        if (cnt == '0) begin
          gate_d  = 1'b0;
          state_d = WAIT_DROP;
        end else cnt_d = cnt - CNT_W'(1);
      WAIT_DROP: state_d = arrive_req ? WAIT_DROP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      occupancy     <= '0;
      assigned_spot <= '0;
      arrive_ack    <= 1'b0;
      arrive_nack   <= 1'b0;
      gate_open     <= 1'b0;
      exit_err      <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      occupancy     <= (occupancy | set_mask) & ~clr_mask;
      assigned_spot <= spot_d;
      arrive_ack    <= ack_d;
      arrive_nack   <= nack_d;
      gate_open     <= gate_d;
      exit_err      <= err_d;
    end
  end
endmodule
